// File: rtl/sequence_generator.sv
// -----------------------------------------------------------------------------
// sequence_generator
//
// Serial pattern transmitter. Parallel words are accepted over a valid/ready
// handshake and shifted out one bit per clock, MSB first. When the macro
// SEQGEN_PREAMBLE_EN is defined, every word is prefixed with the 4-bit sync
// preamble 1101. A shadow tracker counts the non-overlapping 1101 matches in
// the emitted stream, so the count can be set against the receive-side
// detector directly.
//
// Parameters:
//   WIDTH        payload bits per word (>= 4)
//   CNT_W        width of match_count
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   load_valid   load_data is valid
//   load_ready   block can accept a word this cycle (decoded from state only)
//   load_data    word to transmit, bit WIDTH-1 sent first
//   out          serial bit
//   out_valid    out carries a preamble or payload bit
//   busy         transmit FSM is not idle
//   done         high while the last payload bit is on out
//   match_count  saturating count of 1101 matches since reset
//
// Configuration macro: SEQGEN_PREAMBLE_EN (undefined = no preamble).
// -----------------------------------------------------------------------------
//
// Transmit FSM
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | nothing on out; waiting for a word
//   S_PRE  | preamble bit pre_cnt_q is on out (down-count 3..0)
//   S_DATA | payload bit bit_cnt_q is on out (0 = MSB)
//
// Shadow tracker
//   state  | meaning
//   -------+-----------------------------------------------------------
//   M0     | no useful prefix seen
//   M1     | "1" seen
//   M2     | "11" seen
//   M3     | "110" seen
// -----------------------------------------------------------------------------

module sequence_generator #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_count
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

`ifdef SEQGEN_PREAMBLE_EN
    // Indexed by the preamble down-counter: index 3 goes out first.
    localparam logic [3:0] PREAMBLE = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_DATA = 2'd2
    } tx_state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd2
    } tx_state_t;
`endif

    typedef enum logic [1:0] {
        M0 = 2'd0,
        M1 = 2'd1,
        M2 = 2'd2,
        M3 = 2'd3
    } trk_state_t;

    tx_state_t        state_q;
    tx_state_t        state_n;
    logic [BW-1:0]    bit_cnt_q;
    logic [BW-1:0]    bit_cnt_n;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_n;
`ifdef SEQGEN_PREAMBLE_EN
    logic [1:0]       pre_cnt_q;
    logic [1:0]       pre_cnt_n;
`endif

    logic             last_bit;
    logic             accept;
    logic             out_n;
    logic             out_valid_n;
    logic             busy_n;
    logic             done_n;

    trk_state_t       trk_q;
    trk_state_t       trk_n;
    logic             match_inc;

    // -------------------------------------------------------------------------
    // Handshake: ready depends only on the registered state, so a word offered
    // during the last payload bit is taken without a gap.
    // -------------------------------------------------------------------------
    assign last_bit   = (state_q == S_DATA) && (bit_cnt_q == LAST_BIT);
    assign load_ready = (state_q == S_IDLE) || last_bit;
    assign accept     = load_valid && load_ready;

    // -------------------------------------------------------------------------
    // Transmit FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_n   = state_q;
        bit_cnt_n = bit_cnt_q;
        shift_n   = shift_q;
`ifdef SEQGEN_PREAMBLE_EN
        pre_cnt_n = pre_cnt_q;
`endif

        // accept can only be true in S_IDLE or in the last payload bit, so it
        // takes priority over the per-state behaviour below.
        if (accept) begin
            shift_n   = load_data;
            bit_cnt_n = '0;
`ifdef SEQGEN_PREAMBLE_EN
            state_n   = S_PRE;
            pre_cnt_n = 2'd3;
`else
            state_n   = S_DATA;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_n = S_IDLE;
                end
`ifdef SEQGEN_PREAMBLE_EN
                S_PRE: begin
                    // The word's MSB is already in shift_q[WIDTH-1], so the
                    // hand-over to S_DATA needs no shift.
                    if (pre_cnt_q == 2'd0) begin
                        state_n = S_DATA;
                    end else begin
                        pre_cnt_n = pre_cnt_q - 2'd1;
                    end
                end
`endif
                S_DATA: begin
                    if (last_bit) begin
                        state_n = S_IDLE;
                    end else begin
                        bit_cnt_n = bit_cnt_q + BW'(1);
                        shift_n   = {shift_q[WIDTH-2:0], 1'b0};
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output decode from the next state, so every output is a flop that shows
    // the bit belonging to the state being entered.
    // -------------------------------------------------------------------------
    always_comb begin
        out_n       = 1'b0;
        out_valid_n = (state_n != S_IDLE);
        busy_n      = (state_n != S_IDLE);
        done_n      = (state_n == S_DATA) && (bit_cnt_n == LAST_BIT);
        case (state_n)
`ifdef SEQGEN_PREAMBLE_EN
            S_PRE:   out_n = PREAMBLE[pre_cnt_n];
`endif
            S_DATA:  out_n = shift_n[WIDTH-1];
            default: out_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
`ifdef SEQGEN_PREAMBLE_EN
            pre_cnt_q <= 2'd0;
`endif
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_n;
            bit_cnt_q <= bit_cnt_n;
            shift_q   <= shift_n;
`ifdef SEQGEN_PREAMBLE_EN
            pre_cnt_q <= pre_cnt_n;
`endif
            out       <= out_n;
            out_valid <= out_valid_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    // -------------------------------------------------------------------------
    // Shadow 1101 tracker. It watches the registered serial output, so a match
    // is counted on the edge after the 4th pattern bit is on out. Idle cycles
    // freeze it, letting a pattern span word boundaries and gaps.
    // -------------------------------------------------------------------------
    always_comb begin
        trk_n     = trk_q;
        match_inc = 1'b0;
        if (out_valid) begin
            case (trk_q)
                M0: trk_n = out ? M1 : M0;
                M1: trk_n = out ? M2 : M0;
                M2: trk_n = out ? M2 : M3;
                M3: begin
                    // Non-overlapping: a completed match restarts from scratch.
                    trk_n     = M0;
                    match_inc = out;
                end
                default: trk_n = M0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trk_q       <= M0;
            match_count <= '0;
        end else begin
            trk_q <= trk_n;
            if (match_inc && (match_count != {CNT_W{1'b1}})) begin
                match_count <= match_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sequence_generator.sv
// -----------------------------------------------------------------------------
// tb_sequence_generator
//
// Drives directed and random words into two copies of sequence_generator
// (CNT_W=8 and CNT_W=2) and compares every output each cycle against a
// queue-based model: accepted words expand into a queue of expected bits, and
// the match count is a non-overlapping search for 1101 over the emitted history.
// Honours SEQGEN_PREAMBLE_EN the same way as the design.
// -----------------------------------------------------------------------------

module tb_sequence_generator;

    localparam int WIDTH = 16;
`ifdef SEQGEN_PREAMBLE_EN
    localparam int PRE_LEN    = 4;
    localparam int DADD_MATCH = 4;
    localparam int B2B_MATCH  = 2;
`else
    localparam int PRE_LEN    = 0;
    localparam int DADD_MATCH = 3;
    localparam int B2B_MATCH  = 1;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             load_valid;
    logic [WIDTH-1:0] load_data;

    logic             load_ready;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             done;
    logic [7:0]       match_count;

    logic             s_load_ready;
    logic             s_out;
    logic             s_out_valid;
    logic             s_busy;
    logic             s_done;
    logic [1:0]       s_match_count;

    always #5 clk = ~clk;

    sequence_generator #(.WIDTH(WIDTH), .CNT_W(8)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .out         (out),
        .out_valid   (out_valid),
        .busy        (busy),
        .done        (done),
        .match_count (match_count)
    );

    sequence_generator #(.WIDTH(WIDTH), .CNT_W(2)) u_sat (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (s_load_ready),
        .load_data   (load_data),
        .out         (s_out),
        .out_valid   (s_out_valid),
        .busy        (s_busy),
        .done        (s_done),
        .match_count (s_match_count)
    );

    int         tests = 0;
    int         errors = 0;

    // Model state: queue of {last_payload_bit, bit}; front is the bit on out.
    logic [1:0] exp_q[$];
    logic       hist[$];
    int         match_end = 0;
    int         exp_cnt = 0;
    logic       last_accept = 1'b0;
    logic [3:0] pre_pat = 4'b1101;

    int         ov_cycles = 0;
    int         done_pulses = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic model_ready();
        return (exp_q.size() == 0) || (exp_q.size() == 1 && exp_q[0][1]);
    endfunction

    task automatic model_step();
        logic acc;
        logic b;
        int   n;
        if (rst) begin
            exp_q.delete();
            hist.delete();
            match_end   = 0;
            exp_cnt     = 0;
            last_accept = 1'b0;
        end else begin
            acc = load_valid && model_ready();
            if (exp_q.size() > 0) begin
                b = exp_q[0][0];
                void'(exp_q.pop_front());
                hist.push_back(b);
                n = hist.size();
                if (n >= 4 && (n - 4) >= match_end &&
                    hist[n-4] && hist[n-3] && !hist[n-2] && hist[n-1]) begin
                    exp_cnt++;
                    match_end = n;
                end
            end
            if (acc) begin
                for (int i = 0; i < PRE_LEN; i++) exp_q.push_back({1'b0, pre_pat[3-i]});
                for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back({logic'(i == 0), load_data[i]});
            end
            last_accept = acc;
        end
    endtask

    task automatic check_all();
        logic eo;
        logic ed;
        eo = (exp_q.size() > 0) ? exp_q[0][0] : 1'b0;
        ed = (exp_q.size() > 0) ? exp_q[0][1] : 1'b0;
        check_eq("out",         out,         eo);
        check_eq("out_valid",   out_valid,   exp_q.size() > 0);
        check_eq("busy",        busy,        exp_q.size() > 0);
        check_eq("done",        done,        ed);
        check_eq("load_ready",  load_ready,  model_ready());
        check_eq("match_count", match_count, (exp_cnt > 255) ? 255 : exp_cnt);
        check_eq("sat_count",   s_match_count, (exp_cnt > 3) ? 3 : exp_cnt);
        check_eq("sat_out",     s_out,       eo);
        if (out_valid) ov_cycles++;
        if (done) done_pulses++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ov_cycles   = 0;
        done_pulses = 0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        load_valid  = 1'b1;
        load_data   = w;
        last_accept = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (last_accept) break;
        end
        check_eq("accept_timeout", last_accept, 1'b1);
    endtask

    task automatic wait_idle();
        load_valid = 1'b0;
        for (int k = 0; k < 200 && exp_q.size() > 0; k++) tick();
        check_eq("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;

        // Reset state
        tick();
        tick();
        check_eq("rst_ready", load_ready, 1'b1);
        check_eq("rst_ovalid", out_valid, 1'b0);
        check_eq("rst_mc", match_count, 0);
        rst = 1'b0;

        // Single word
        do_reset();
        send_word(16'hDADD);
        wait_idle();
        check_eq("dadd_count", match_count, DADD_MATCH);
        check_eq("dadd_ov", ov_cycles, WIDTH + PRE_LEN);
        check_eq("dadd_done", done_pulses, 1);

        // Back-to-back with valid held high
        do_reset();
        send_word(16'hFFFF);
        send_word(16'h4000);
        wait_idle();
        check_eq("b2b_count", match_count, B2B_MATCH);
        check_eq("b2b_ov", ov_cycles, 2 * (WIDTH + PRE_LEN));
        check_eq("b2b_done", done_pulses, 2);

        // Handshake stall: data churns every cycle while not ready
        do_reset();
        send_word(16'h1234);
        for (int i = 0; i < WIDTH + PRE_LEN + 3; i++) begin
            load_valid = 1'b1;
            load_data  = WIDTH'($urandom);
            tick();
        end
        wait_idle();
        check_eq("stall_done", done_pulses, 2);

        // Reset in the middle of a word
        do_reset();
        send_word(16'hA5C3);
        load_valid = 1'b0;
        repeat (PRE_LEN + 5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_ovalid", out_valid, 1'b0);
        check_eq("mid_out", out, 1'b0);
        check_eq("mid_busy", busy, 1'b0);
        check_eq("mid_mc", match_count, 0);
        check_eq("mid_nodone", done_pulses, 0);
        send_word(16'hDADD);
        wait_idle();
        check_eq("after_mid", match_count, DADD_MATCH);

        // Saturation of the narrow counter
        do_reset();
        for (int i = 0; i < 4; i++) send_word(16'hDADD);
        wait_idle();
        check_eq("sat_stick", s_match_count, 3);
        check_eq("full_cnt", match_count, 4 * DADD_MATCH);

        // Random traffic with occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 299) == 0);
            load_valid = ($urandom_range(0, 2) == 0);
            load_data  = ($urandom_range(0, 3) == 0) ? 16'hDADD : WIDTH'($urandom);
            tick();
        end
        rst = 1'b0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
